// File: rtl/dice_game_ctrl_if.sv
// Player/dice/display signal bundle for dice_game_ctrl.
// The controller uses the slave modport; the player and dice side uses master.
interface dice_game_ctrl_if #(
    parameter int SCORE_W = 6
);
    logic               btn_a;
    logic               btn_b;
    logic               new_game;
    logic [2:0]         throw_in;
    logic               dice_button;
    logic               turn;
    logic [2:0]         last_throw;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               result_valid;
    logic [1:0]         winner;
    logic               game_over;

    modport master (
        output btn_a, btn_b, new_game, throw_in,
        input  dice_button, turn, last_throw, score_a, score_b,
               result_valid, winner, game_over
    );

    modport slave (
        input  btn_a, btn_b, new_game, throw_in,
        output dice_button, turn, last_throw, score_a, score_b,
               result_valid, winner, game_over
    );
endinterface

// File: rtl/dice_game_ctrl.sv
// Two-player dice turn scheduler: roll handshake, settle delay, capture and scoring.
// Optional BONUS_SIX_EN: a non-winning throw of 6 keeps the turn with the same player.
module dice_game_ctrl #(
    parameter int TARGET     = 20,
    parameter int SETTLE_CYC = 2,
    parameter int SCORE_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    dice_game_ctrl_if.slave  bus
);

    localparam logic [2:0] ST_WAIT    = 3'd0;
    localparam logic [2:0] ST_ROLL    = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               turn_q, turn_d;
    logic [2:0]         last_q, last_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic               rv_q, rv_d;
    logic [1:0]         winner_q, winner_d;

    logic               activeBtn;
    logic               validThrow;
    logic               keepTurn;
    logic [SCORE_W-1:0] curScore;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] satScore;

    assign activeBtn  = turn_q ? bus.btn_b : bus.btn_a;
    assign validThrow = (bus.throw_in != 3'd0) && (bus.throw_in != 3'd7);
    assign curScore   = turn_q ? score_b_q : score_a_q;
    assign sum        = {1'b0, curScore} + (SCORE_W+1)'(bus.throw_in);
    // The carry-out means the add overflowed the score width: clamp to all ones.
    assign satScore   = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

`ifdef BONUS_SIX_EN
    assign keepTurn = (bus.throw_in == 3'd6);
`else
    assign keepTurn = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        turn_d    = turn_q;
        last_d    = last_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        rv_d      = 1'b0;
        winner_d  = winner_q;

        case (state_q)
            ST_WAIT: begin
                if (activeBtn) begin
                    state_d = ST_ROLL;
                end
            end
            ST_ROLL: begin
                if (!activeBtn) begin
                    cnt_d   = 4'(SETTLE_CYC);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_WAIT;
                if (validThrow) begin
                    last_d = bus.throw_in;
                    rv_d   = 1'b1;
                    if (turn_q) begin
                        score_b_d = satScore;
                    end else begin
                        score_a_d = satScore;
                    end
                    if (32'(satScore) >= 32'(TARGET)) begin
                        winner_d = turn_q ? 2'b10 : 2'b01;
                        state_d  = ST_DONE;
                    end else if (!keepTurn) begin
                        turn_d = ~turn_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // A new game overrides whatever the FSM decided this cycle, including a pending result pulse.
        if (bus.new_game) begin
            state_d   = ST_WAIT;
            cnt_d     = 4'd0;
            turn_d    = 1'b0;
            last_d    = 3'd0;
            score_a_d = '0;
            score_b_d = '0;
            rv_d      = 1'b0;
            winner_d  = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_WAIT;
            cnt_q     <= 4'd0;
            turn_q    <= 1'b0;
            last_q    <= 3'd0;
            score_a_q <= '0;
            score_b_q <= '0;
            rv_q      <= 1'b0;
            winner_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            turn_q    <= turn_d;
            last_q    <= last_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            rv_q      <= rv_d;
            winner_q  <= winner_d;
        end
    end

    assign bus.dice_button  = (state_q == ST_ROLL);
    assign bus.game_over    = (state_q == ST_DONE);
    assign bus.turn         = turn_q;
    assign bus.last_throw   = last_q;
    assign bus.score_a      = score_a_q;
    assign bus.score_b      = score_b_q;
    assign bus.result_valid = rv_q;
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: directed scenarios plus randomized games
// compared against a turn-level scoring model.
module tb_dice_game_ctrl;

    localparam int TARGET     = 20;
    localparam int SETTLE_CYC = 2;
    localparam int SCORE_W    = 6;
    localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dice_game_ctrl_if #(.SCORE_W(SCORE_W)) bus();

    dice_game_ctrl #(
        .TARGET    (TARGET),
        .SETTLE_CYC(SETTLE_CYC),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int numChecks = 0;
    int numFails  = 0;

    // Game model: whole-turn view of the rules, no notion of internal states.
    int mScore[2];
    int mTurn;
    int mLast;
    int mWinner;
    bit mDone;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        mScore[0] = 0;
        mScore[1] = 0;
        mTurn     = 0;
        mLast     = 0;
        mWinner   = 0;
        mDone     = 1'b0;
    endtask

    task automatic modelThrow(input int t);
        int s;
        if (t >= 1 && t <= 6) begin
            mLast = t;
            s = mScore[mTurn] + t;
            if (s > SCORE_MAX) s = SCORE_MAX;
            mScore[mTurn] = s;
            if (s >= TARGET) begin
                mWinner = mTurn + 1;
                mDone   = 1'b1;
            end else begin
`ifdef BONUS_SIX_EN
                if (t != 6) mTurn = 1 - mTurn;
`else
                mTurn = 1 - mTurn;
`endif
            end
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".turn"},     32'(bus.turn),       32'(mTurn));
        checkOutput({tag, ".scoreA"},   32'(bus.score_a),    32'(mScore[0]));
        checkOutput({tag, ".scoreB"},   32'(bus.score_b),    32'(mScore[1]));
        checkOutput({tag, ".last"},     32'(bus.last_throw), 32'(mLast));
        checkOutput({tag, ".winner"},   32'(bus.winner),     32'(mWinner));
        checkOutput({tag, ".gameOver"}, 32'(bus.game_over),  32'(mDone));
        checkOutput({tag, ".diceBtn"},  32'(bus.dice_button), 32'd0);
    endtask

    task automatic driveButtons(input logic act, input logic inact);
        if (mTurn == 0) begin
            bus.btn_a = act;
            bus.btn_b = inact;
        end else begin
            bus.btn_b = act;
            bus.btn_a = inact;
        end
    endtask

    // One full turn: hold the active button for 'hold' cycles with throw_in held at t,
    // then follow the settle window to the capture and compare against the model.
    task automatic applyStimulus(input int hold, input int t);
        int  dbHigh = 0;
        int  rvHigh = 0;
        bit  valid  = (t >= 1 && t <= 6);
        @(posedge clk); #1;
        bus.throw_in = 3'(t);
        driveButtons(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            driveButtons((i == hold - 1) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (bus.dice_button) dbHigh++;
            if (bus.result_valid) rvHigh++;
        end
        for (int j = 0; j <= SETTLE_CYC + 1; j++) begin
            @(posedge clk); #1;
            driveButtons(1'b0, (j == SETTLE_CYC + 1) ? 1'b0 : 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (bus.dice_button) dbHigh++;
            if (bus.result_valid) rvHigh++;
            if (j == SETTLE_CYC + 1) checkOutput("rvAtCapture", 32'(bus.result_valid), 32'(valid));
        end
        driveButtons(1'b0, 1'b0);
        modelThrow(t);
        checkOutput("diceBtnCycles", 32'(dbHigh), 32'(hold));
        checkOutput("rvPulseCount", 32'(rvHigh), 32'(valid));
        checkState("afterTurn");
    endtask

    task automatic newGame();
        @(posedge clk); #1;
        bus.new_game = 1'b1;
        @(posedge clk); #1;
        bus.new_game = 1'b0;
        modelClear();
        @(negedge clk);
        checkState("newGame");
    endtask

    initial begin
        int dbCount;
        int turns;

        bus.btn_a    = 1'b0;
        bus.btn_b    = 1'b0;
        bus.new_game = 1'b0;
        bus.throw_in = 3'd0;
        modelClear();

        #1 rst = 1'b0;
        #2;
        checkState("reset");
        checkOutput("resetRv", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Inactive player's button must be ignored.
        @(posedge clk); #1;
        bus.btn_b = 1'b1;
        @(posedge clk); #1;
        bus.btn_b = 1'b0;
        dbCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.dice_button) dbCount++;
        end
        checkOutput("inactiveBtnDb", 32'(dbCount), 32'd0);
        checkState("inactiveBtn");

        applyStimulus(2, 7);
        applyStimulus(4, 3);
        checkOutput("firstScoreA", 32'(bus.score_a), 32'd3);
        checkOutput("firstTurn", 32'(bus.turn), 32'd1);

        // Asynchronous reset while player B is rolling.
        @(posedge clk); #1;
        bus.btn_b = 1'b1;
        @(posedge clk); #1;
        checkOutput("midRollDb", 32'(bus.dice_button), 32'd1);
        #2 rst = 1'b0;
        #1;
        modelClear();
        checkState("midRollReset");
        bus.btn_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Drive A to 18 with sixes, then a 4 to win; B throws ones.
        turns = 0;
        while (!mDone && turns < 20) begin
            if (mTurn == 0) applyStimulus(1, (mScore[0] >= 18) ? 4 : 6);
            else            applyStimulus(1, 1);
            turns++;
        end
        checkOutput("winScoreA", 32'(bus.score_a), 32'd22);
        checkOutput("winWinner", 32'(bus.winner), 32'd1);
        checkOutput("winGameOver", 32'(bus.game_over), 32'd1);

        // Presses after the game ends are ignored.
        dbCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.btn_a    = 1'b1;
            bus.btn_b    = 1'b1;
            bus.throw_in = 3'($urandom_range(1, 6));
            @(negedge clk);
            if (bus.dice_button) dbCount++;
        end
        bus.btn_a = 1'b0;
        bus.btn_b = 1'b0;
        checkOutput("doneDb", 32'(dbCount), 32'd0);
        checkState("doneHold");

        newGame();

        // B throws 6 from 5.
        applyStimulus(1, 1);
        applyStimulus(1, 5);
        applyStimulus(1, 1);
        applyStimulus(1, 6);
        checkOutput("sixScoreB", 32'(bus.score_b), 32'd11);
`ifdef BONUS_SIX_EN
        checkOutput("sixTurn", 32'(bus.turn), 32'd1);
`else
        checkOutput("sixTurn", 32'(bus.turn), 32'd0);
`endif

        // Randomized games.
        for (int g = 0; g < 3; g++) begin
            newGame();
            turns = 0;
            while (!mDone && turns < 60) begin
                applyStimulus($urandom_range(1, 4), $urandom_range(0, 7));
                turns++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Two-player turn scheduler for the shared electronic dice. Arbitrates the single dice between player A and player B, drives the dice's roll button, captures the settled throw and accumulates per-player scores until one player reaches a target score. Sits between the two player push-buttons and the dice block, and feeds the score/status display.

## Interface

Parameters:
- TARGET, 20: score at or above which the current player wins.
- SETTLE_CYC, 2: cycles spent in SETTLE after release before capture. Legal values are 1 to 15.
- SCORE_W, 6: width of each score register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_a  in  1  player A roll button, synchronous, high = pressed.
- btn_b  in  1  player B roll button, synchronous, high = pressed.
- new_game  in  1  synchronous clear of the game, honoured in any state.
- throw_in  in  3  current dice value from the dice block.
- dice_button  out  1  roll request to the dice block.
- turn  out  1  0 = player A's turn, 1 = player B's turn.
- last_throw  out  3  most recently captured valid throw.
- score_a  out  SCORE_W  player A accumulated score.
- score_b  out  SCORE_W  player B accumulated score.
- result_valid  out  1  one-cycle pulse when a throw is scored.
- winner  out  2  00 = none, 01 = A, 10 = B; 11 is never driven.
- game_over  out  1  high while in DONE.

## Operation

- Reset values while rst is low: state WAIT, turn=0, scores=0, last_throw=0, winner=00, result_valid=0, dice_button=0, game_over=0.
- Active button: btn_a when turn=0, btn_b when turn=1. The inactive player's button is ignored in every state.
- FSM states and transitions:
  - WAIT: if the active button is high, go to ROLL.
  - ROLL: dice_button=1. Stay while the active button is high. When it is low, load the settle counter with SETTLE_CYC and go to SETTLE.
  - SETTLE: dice_button=0. Decrement the counter. When the counter reaches 1, go to CAPTURE.
  - CAPTURE: sample throw_in.
    - Invalid sample (0 or 7): discard it. Scores, turn and last_throw are unchanged, and result_valid is not pulsed. Go to WAIT, so the same player rolls again.
    - Valid sample (1 to 6): last_throw <= throw_in and add it to the active player's score. The add saturates at 2^SCORE_W-1; it never wraps. Pulse result_valid.
    - If the new score is at or above TARGET: set winner to the active player and go to DONE. turn is unchanged.
    - Otherwise toggle turn, subject to Configuration, and go to WAIT.
  - DONE: game_over=1. Outputs hold and all buttons are ignored.
- new_game, honoured in any state: next state WAIT, turn=0, scores=0, last_throw=0, winner=00. It has priority over every other transition. A result_valid pulse that would have fired on that edge is suppressed.
- Zero-extend throw_in to SCORE_W before the add.

## Timing

- dice_button, game_over and turn are Moore outputs, decoded from registers only, so they are glitch-free.
- Press sampled high at edge N: dice_button is high from edge N.
- Release sampled at edge M: dice_button is low from edge M.
- throw_in is sampled at edge M+SETTLE_CYC+1.
- Score, last_throw and turn are updated, and result_valid is high, for the single cycle after that same edge.
- Minimum press is one cycle: ROLL lasts at least one cycle.
- Both buttons high in WAIT: only the active one counts.
- An asynchronous reset mid-roll returns to WAIT immediately, with dice_button low without waiting for a clock.

## Configuration

- BONUS_SIX_EN defined: a valid throw of 6 that does not win keeps turn unchanged, giving the same player an extra roll.
- BONUS_SIX_EN undefined: turn always toggles after a valid, non-winning throw.

## Test plan

- Reset: drive rst low mid-ROLL -> dice_button=0, scores=0, turn=0, winner=00 with no clock edge.
- A presses for 4 cycles, throw_in=3 settled, SETTLE_CYC=2 -> dice_button high exactly 4 cycles, result_valid pulse 3 cycles after release, score_a=3, turn=1.
- With turn=0, btn_b pulsed -> no ROLL, dice_button stays 0, no change to any output.
- throw_in=7 at capture -> no result_valid, score_a unchanged, turn stays 0, next btn_a press starts ROLL.
- score_a=18, A throws 4 -> score_a=22, winner=01, game_over=1. Further presses ignored. new_game -> scores 0, turn 0, WAIT.
- B throws 6 with score_b=5 -> score_b=11. turn stays 1 with BONUS_SIX_EN; turn becomes 0 without it.
